sm83_bus_responder: RTL and testbench

//  Responder end of the SM83 CPU memory bus. Accepts one CPU request at a time,

---
 rtl/sm83_bus_responder.sv | 120 ++++++++++++
 tb/tb_sm83_bus_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sm83_bus_responder.sv
// SM83 memory-bus responder: decodes CPU requests to boot ROM, WRAM/echo or unmapped
// space, strobes the device for a per-region wait count, and owns the 0xFF50 boot latch.
module sm83_bus_responder #(
    parameter int unsigned ROM_WAIT  = 1,
    parameter int unsigned WRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        rom_cs,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic        wram_cs,
    output logic        wram_we,
    output logic [12:0] wram_addr,
    output logic [7:0]  wram_wdata,
    input  logic [7:0]  wram_rdata,
    output logic        boot_en
);

    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {RGN_ROM, RGN_WRAM, RGN_REG, RGN_UNMAP} region_t;

    state_t              state;
    region_t             region;
    region_t             region_d;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wait_d;
    logic                we_q;
    logic [7:0]          wdata_q;

    // Address decode against the current boot latch; only used when latching in IDLE.
    always_comb begin
        region_d = RGN_UNMAP;
        wait_d   = '0;
        if (addr[15:8] == 8'h00 && boot_en) begin
            region_d = RGN_ROM;
            wait_d   = WCNT_W'(ROM_WAIT);
        end else if (addr >= 16'hC000 && addr <= 16'hFDFF) begin
            region_d = RGN_WRAM;
            wait_d   = WCNT_W'(WRAM_WAIT);
        end else if (addr == 16'hFF50) begin
            region_d = RGN_REG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            region     <= RGN_UNMAP;
            wcnt       <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata      <= 8'hFF;
            ack        <= 1'b0;
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            wram_cs    <= 1'b0;
            wram_we    <= 1'b0;
            wram_addr  <= '0;
            wram_wdata <= '0;
            boot_en    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        state      <= ACCESS;
                        region     <= region_d;
                        wcnt       <= wait_d;
                        we_q       <= we;
                        wdata_q    <= wdata;
                        rom_cs     <= (region_d == RGN_ROM);
                        rom_addr   <= addr[7:0];
                        wram_cs    <= (region_d == RGN_WRAM);
                        wram_addr  <= addr[12:0];
                        wram_wdata <= wdata;
                        // Write strobe is raised only for the final ACCESS cycle.
                        wram_we    <= we && (region_d == RGN_WRAM) && (wait_d == '0);
                    end
                end
                ACCESS: begin
                    if (wcnt != '0) begin
                        wcnt    <= wcnt - WCNT_W'(1);
                        wram_we <= we_q && (region == RGN_WRAM) && (wcnt == WCNT_W'(1));
                    end else begin
                        state   <= RESP;
                        ack     <= 1'b1;
                        rom_cs  <= 1'b0;
                        wram_cs <= 1'b0;
                        wram_we <= 1'b0;
                        if (!we_q) begin
                            case (region)
                                RGN_ROM:  rdata <= rom_rdata;
                                RGN_WRAM: rdata <= wram_rdata;
                                RGN_REG:  rdata <= {7'h7F, ~boot_en};
                                default:  rdata <= 8'hFF;
                            endcase
                        end else if (region == RGN_REG && wdata_q != 8'h00) begin
                            boot_en <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Directed bench for sm83_bus_responder with behavioural ROM/WRAM models and an
// expectation queue popped on each ack.
module tb_sm83_bus_responder;

    localparam int ROM_W  = 1;
    localparam int WRAM_W = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ack;
    logic        rom_cs;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_rdata = '0;
    logic        wram_cs;
    logic        wram_we;
    logic [12:0] wram_addr;
    logic [7:0]  wram_wdata;
    logic [7:0]  wram_rdata = '0;
    logic        boot_en;

    sm83_bus_responder #(.ROM_WAIT(ROM_W), .WRAM_WAIT(WRAM_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_rdata(rom_rdata), .wram_cs(wram_cs), .wram_we(wram_we),
        .wram_addr(wram_addr), .wram_wdata(wram_wdata), .wram_rdata(wram_rdata),
        .boot_en(boot_en)
    );

    always #5 clk = ~clk;

    // Synchronous single-cycle-latency device models.
    logic [7:0] wram_mem [0:8191];
    always @(posedge clk) begin
        if (wram_cs) begin
            if (wram_we) wram_mem[wram_addr] <= wram_wdata;
            wram_rdata <= wram_mem[wram_addr];
        end
        if (rom_cs) rom_rdata <= (rom_addr == 8'h42) ? 8'h31 : ~rom_addr;
    end

    // Strobe activity counters, cleared at the start of each transaction.
    int          n_rom, n_wram, n_we;
    logic [12:0] we_addr;
    always @(negedge clk) begin
        if (rom_cs)  n_rom++;
        if (wram_cs) n_wram++;
        if (wram_we) begin
            n_we++;
            we_addr = wram_addr;
        end
    end

    typedef struct {
        int         lat;
        logic [7:0] rd;
        int         nrom;
        int         nwram;
        int         nwe;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One isolated transaction, started just after a posedge with the DUT in IDLE.
    task automatic txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                       input int lat, input logic [7:0] rd, input int nrom,
                       input int nwram, input int nwe, input string tag);
        exp_t e;
        int   k;
        logic got;
        e = '{lat, rd, nrom, nwram, nwe};
        sb.push_back(e);
        n_rom = 0; n_wram = 0; n_we = 0;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        k = 0; got = 1'b0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (ack) got = 1'b1;
        end
        req = 1'b0;
        e = sb.pop_front();
        chk({tag, " ack"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(k), 32'(e.lat));
        chk({tag, " rdata"}, 32'(rdata), 32'(e.rd));
        chk({tag, " rom_cs cycles"}, 32'(n_rom), 32'(e.nrom));
        chk({tag, " wram_cs cycles"}, 32'(n_wram), 32'(e.nwram));
        chk({tag, " wram_we pulses"}, 32'(n_we), 32'(e.nwe));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks, first, second;

        // Power-on reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst rdata", 32'(rdata), 32'hFF);
        chk("rst boot_en", 32'(boot_en), 32'd1);
        chk("rst strobes", 32'({rom_cs, wram_cs, wram_we}), 32'd0);
        chk("rst addrs", 32'({rom_addr, wram_addr}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T2: boot ROM read
        txn(1'b0, 16'h0042, 8'h00, ROM_W + 2, 8'h31, ROM_W + 1, 0, 0, "rom_rd");
        // T3: WRAM write then echo read; rdata holds across the write
        txn(1'b1, 16'hC123, 8'hA5, WRAM_W + 2, 8'h31, 0, WRAM_W + 1, 1, "wram_wr");
        chk("wram_wr addr", 32'(we_addr), 32'h0123);
        txn(1'b0, 16'hE123, 8'h00, WRAM_W + 2, 8'hA5, 0, WRAM_W + 1, 0, "echo_rd");
        // T5: unmapped accesses
        txn(1'b0, 16'h8000, 8'h00, 2, 8'hFF, 0, 0, 0, "unmap_rd");
        txn(1'b1, 16'hFE00, 8'h77, 2, 8'hFF, 0, 0, 0, "unmap_wr");
        txn(1'b0, 16'hDFFF, 8'h00, WRAM_W + 2, 8'hXX, 0, WRAM_W + 1, 0, "wram_top_probe");
        txn(1'b0, 16'hC123, 8'h00, WRAM_W + 2, 8'hA5, 0, WRAM_W + 1, 0, "wram_rd");
        // T4: boot latch; zero write is a no-op, nonzero disables the ROM
        txn(1'b1, 16'hFF50, 8'h00, 2, 8'hA5, 0, 0, 0, "reg_wr0");
        chk("boot_en after 0", 32'(boot_en), 32'd1);
        txn(1'b0, 16'hFF50, 8'h00, 2, 8'hFE, 0, 0, 0, "reg_rd_on");
        txn(1'b1, 16'hFF50, 8'h01, 2, 8'hFE, 0, 0, 0, "reg_wr1");
        chk("boot_en after 1", 32'(boot_en), 32'd0);
        txn(1'b0, 16'hFF50, 8'h00, 2, 8'hFF, 0, 0, 0, "reg_rd_off");
        txn(1'b0, 16'h0000, 8'h00, 2, 8'hFF, 0, 0, 0, "rom_off_rd");

        // T1: reset asserted while a WRAM write is in ACCESS
        req = 1'b1; we = 1'b1; addr = 16'hC200; wdata = 8'h5A;
        @(posedge clk); #1;
        chk("t1 in access", 32'(wram_cs), 32'd1);
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t1 ack", 32'(ack), 32'd0);
        chk("t1 strobes", 32'({rom_cs, wram_cs, wram_we}), 32'd0);
        chk("t1 rdata", 32'(rdata), 32'hFF);
        chk("t1 boot_en", 32'(boot_en), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("t1 no late ack", 32'(acks), 32'd0);
        @(posedge clk); #1;
        txn(1'b0, 16'h0042, 8'h00, ROM_W + 2, 8'h31, ROM_W + 1, 0, 0, "rom_rd_after_rst");

        // T6: req held through ack gives a second transaction after one IDLE cycle
        req = 1'b1; we = 1'b0; addr = 16'hE123;
        @(posedge clk);
        acks = 0; first = 0; second = 0;
        for (int i = 1; i <= 30 && acks < 2; i++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (acks == 1) first = i;
                else second = i;
            end
        end
        req = 1'b0;
        chk("b2b acks", 32'(acks), 32'd2);
        chk("b2b first", 32'(first), 32'(WRAM_W + 2));
        chk("b2b gap", 32'(second - first), 32'(WRAM_W + 3));
        chk("b2b rdata", 32'(rdata), 32'hA5);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("b2b no extra ack", 32'(acks), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
